// File: rtl/pc_update_pkg.sv
// ---------------------------------------------------------------------------
// pc_update_pkg
// Shared definitions for the fetch-side PC logic and the instruction memory.
// Holds the default datapath width, the icode constants, the processor
// status codes and the PC-update state encoding.
// ---------------------------------------------------------------------------
package pc_update_pkg;

    // Default width of PC, valC, valM and valP
    localparam int DATA_WID = 64;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // PC update controller states
    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_RET,
        ST_HALT,
        ST_ERR
    } pc_state_e;

endpackage

// File: rtl/pc_update_ins_length.sv
// ---------------------------------------------------------------------------
// ins_length
// Purely combinational decode of the instruction length in bytes from icode.
// Ports:
//   icode_i   - opcode of the instruction at the current PC
//   length_o  - instruction length in bytes (1, 2, 9 or 10)
//   invalid_o - high when icode is not a defined instruction (C..F)
// ---------------------------------------------------------------------------
module ins_length
    import pc_update_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [3:0] length_o,
    output logic       invalid_o
);

    // Undefined opcodes report length 1 so valP stays well defined; the
    // invalid flag is what the controller actually acts on.
    always_comb begin
        length_o  = 4'd1;
        invalid_o = 1'b0;
        case (icode_i)
            I_HALT, I_NOP, I_RET:                length_o = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    length_o = 4'd2;
            I_JXX, I_CALL:                       length_o = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        length_o = 4'd10;
            default:                             invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_update.sv
// ---------------------------------------------------------------------------
// pc_update
// Program counter register and next-PC selection for a sequential Y86-64
// style fetch stage. PC drives the instruction memory directly.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   stall        - freeze PC, state and retired count this cycle
//   icode, valC  - opcode and constant/target field at the current PC
//   cnd          - jXX condition outcome
//   valM         - return address for ret, qualified by valM_valid
//   PC           - registered fetch address
//   valP         - PC + length of the current instruction
//   fetch_valid  - icode/valC are meaningful this cycle
//   stat         - 1 AOK, 2 HLT, 3 ADR, 4 INS
//   retired      - saturating count of PC advances since reset
// ---------------------------------------------------------------------------
module pc_update #(
    parameter int                            DATA_WID   = pc_update_pkg::DATA_WID,
    parameter int                            INS_LENGTH = 2048,
    parameter logic [DATA_WID-1:0]           RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [3:0]          icode,
    input  logic [DATA_WID-1:0] valC,
    input  logic                cnd,
    input  logic [DATA_WID-1:0] valM,
    input  logic                valM_valid,
    output logic [DATA_WID-1:0] PC,
    output logic [DATA_WID-1:0] valP,
    output logic                fetch_valid,
    output logic [2:0]          stat,
    output logic [31:0]         retired
);

    import pc_update_pkg::*;

    // Highest PC from which a maximum-length (10 byte) instruction still fits
    localparam logic [DATA_WID-1:0] ADDR_LIMIT = DATA_WID'(INS_LENGTH - 10);

    pc_state_e           stateQ, stateD;
    logic [DATA_WID-1:0] pcQ, pcD;
    logic [2:0]          errStatQ, errStatD;
    logic [31:0]         retiredQ, retiredD;
    logic [3:0]          insLen;
    logic                insInvalid;
    logic                pcAdvance;

    ins_length u_ins_length (
        .icode_i   (icode),
        .length_o  (insLen),
        .invalid_o (insInvalid)
    );

    assign valP = pcQ + {{(DATA_WID-4){1'b0}}, insLen};

    // Next-state and next-PC selection. The address check runs before the
    // opcode is looked at, so a bad fetch address wins over a bad opcode.
    // A not-taken jump whose fall-through equals its target is treated as
    // no PC change at all, so it also does not count as retired.
    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        errStatD = errStatQ;
        case (stateQ)
            ST_RUN: begin
                if (pcQ > ADDR_LIMIT) begin
                    stateD   = ST_ERR;
                    errStatD = STAT_ADR;
                end else if (insInvalid) begin
                    stateD   = ST_ERR;
                    errStatD = STAT_INS;
                end else begin
                    case (icode)
                        I_HALT: stateD = ST_HALT;
                        I_RET:  stateD = ST_WAIT_RET;
                        I_CALL: pcD    = valC;
                        I_JXX: begin
                            if (cnd) begin
                                pcD = valC;
                            end else if (valP != valC) begin
                                pcD = valP;
                            end
                        end
                        default: pcD = valP;
                    endcase
                end
            end
            ST_WAIT_RET: begin
                if (valM_valid) begin
                    pcD    = valM;
                    stateD = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    // Only live states can move the PC, so any PC difference is an advance
    always_comb begin
        pcAdvance = ((stateQ == ST_RUN) || (stateQ == ST_WAIT_RET)) && (pcD != pcQ);
        retiredD  = retiredQ;
        if (pcAdvance && (retiredQ != 32'hFFFF_FFFF)) begin
            retiredD = retiredQ + 32'd1;
        end
    end

    // State register; reset beats stall, stall beats every other update
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= ST_RUN;
            pcQ      <= RESET_PC;
            errStatQ <= STAT_AOK;
            retiredQ <= '0;
        end else if (!stall) begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            errStatQ <= errStatD;
            retiredQ <= retiredD;
        end
    end

    // Status reflects the current state; the error kind is latched on entry
    always_comb begin
        case (stateQ)
            ST_HALT: stat = STAT_HLT;
            ST_ERR:  stat = errStatQ;
            default: stat = STAT_AOK;
        endcase
    end

    assign PC          = pcQ;
    assign retired     = retiredQ;
    assign fetch_valid = (stateQ == ST_RUN);

endmodule

// File: tb/tb_pc_update.sv
// ---------------------------------------------------------------------------
// tb_pc_update
// Drives pc_update cycle by cycle, predicts the registered outputs with an
// independent behavioural model and compares them through a scoreboard.
// ---------------------------------------------------------------------------
module tb_pc_update;

    localparam int DW = 64;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [2:0]    stat;
        logic [31:0]   retired;
        logic          fetchValid;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic [3:0]    icode = 4'h1;
    logic [DW-1:0] valC  = '0;
    logic          cnd   = 1'b0;
    logic [DW-1:0] valM  = '0;
    logic          valMValid = 1'b0;
    logic [DW-1:0] pc;
    logic [DW-1:0] valP;
    logic          fetchValid;
    logic [2:0]    stat;
    logic [31:0]   retired;

    int totalChecks = 0;
    int badChecks   = 0;

    exp_t expQ[$];

    // Model state: -1 unknown (before first reset), 0 RUN, 1 WAIT_RET, 2 HALT, 3 ERR
    int            mState   = -1;
    logic [DW-1:0] mPc      = '0;
    logic [2:0]    mStat    = 3'd1;
    logic [31:0]   mRetired = '0;

    pc_update #(
        .DATA_WID   (DW),
        .INS_LENGTH (2048),
        .RESET_PC   ('0)
    ) dut (
        .clk         (clock),
        .rst         (reset),
        .stall       (stall),
        .icode       (icode),
        .valC        (valC),
        .cnd         (cnd),
        .valM        (valM),
        .valM_valid  (valMValid),
        .PC          (pc),
        .valP        (valP),
        .fetch_valid (fetchValid),
        .stat        (stat),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Instruction length table; 0 marks an undefined opcode
    function automatic logic [3:0] lenOf(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd0;
        endcase
    endfunction

    // Drive one cycle of inputs, check valP, advance the model, queue the
    // expected registered outputs for after the next rising edge
    task automatic applyStimulus(input logic r, input logic s, input logic [3:0] ic,
                                 input logic [DW-1:0] c, input logic cn,
                                 input logic [DW-1:0] m, input logic mv);
        logic [DW-1:0] vp;
        logic [DW-1:0] nxt;
        exp_t e;
        @(negedge clock);
        reset = r; stall = s; icode = ic; valC = c; cnd = cn; valM = m; valMValid = mv;
        #1;
        vp = mPc + DW'(lenOf(ic));
        if (mState >= 0 && lenOf(ic) != 4'd0) checkOutput("valP", valP, vp);
        if (r) begin
            mPc = '0; mState = 0; mStat = 3'd1; mRetired = '0;
        end else if (!s) begin
            nxt = mPc;
            if (mState == 0) begin
                if (mPc > DW'(2038)) begin
                    mState = 3; mStat = 3'd3;
                end else begin
                    case (ic)
                        4'h0: begin mState = 2; mStat = 3'd2; end
                        4'h9: mState = 1;
                        4'h7: nxt = cn ? c : ((vp == c) ? mPc : vp);
                        4'h8: nxt = c;
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: nxt = vp;
                        default: begin mState = 3; mStat = 3'd4; end
                    endcase
                end
            end else if (mState == 1) begin
                if (mv) begin nxt = m; mState = 0; end
            end
            if (nxt != mPc && mRetired != 32'hFFFF_FFFF) mRetired = mRetired + 32'd1;
            mPc = nxt;
        end
        e.pc = mPc; e.stat = mStat; e.retired = mRetired; e.fetchValid = (mState == 0);
        expQ.push_back(e);
    endtask

    task automatic step(input logic [3:0] ic, input logic [DW-1:0] c, input logic cn);
        applyStimulus(1'b0, 1'b0, ic, c, cn, '0, 1'b0);
    endtask

    // Scoreboard consumer: compare DUT outputs shortly after each rising edge
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc", pc, e.pc);
            checkOutput("stat", DW'(stat), DW'(e.stat));
            checkOutput("retired", DW'(retired), DW'(e.retired));
            checkOutput("fetch_valid", DW'(fetchValid), DW'(e.fetchValid));
        end
    end

    initial begin
        logic [3:0] okCodes [10];
        okCodes = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB};

        // Reset, then three nops
        applyStimulus(1'b1, 1'b0, 4'h1, '0, 1'b0, '0, 1'b0);
        step(4'h1, '0, 1'b0);
        step(4'h1, '0, 1'b0);
        step(4'h1, '0, 1'b0);

        // Conditional jump at 0x10, not taken then taken
        step(4'h7, 64'h10, 1'b1);
        step(4'h7, 64'h40, 1'b0);
        step(4'h7, 64'h10, 1'b1);
        step(4'h7, 64'h40, 1'b1);

        // Every remaining length class, then a call
        step(4'h2, '0, 1'b0);
        step(4'h3, '0, 1'b0);
        step(4'h4, '0, 1'b0);
        step(4'h5, '0, 1'b0);
        step(4'h6, '0, 1'b0);
        step(4'hA, '0, 1'b0);
        step(4'hB, '0, 1'b0);
        step(4'h8, 64'h20, 1'b0);

        // Stall in RUN holds everything
        applyStimulus(1'b0, 1'b1, 4'h1, '0, 1'b0, '0, 1'b0);

        // ret: wait, stalled valM, then accepted
        step(4'h9, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h1, '0, 1'b0, 64'h55, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h1, '0, 1'b0, 64'h30, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h1, '0, 1'b0, 64'h30, 1'b1);

        // Not-taken jump whose fall-through equals its target: no change
        step(4'h7, 64'h39, 1'b0);
        step(4'h1, '0, 1'b0);

        // Halt is terminal until reset
        step(4'h0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'h8, 64'h100, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'h1, '0, 1'b0, '0, 1'b0);

        // Invalid opcode
        step(4'hC, '0, 1'b0);
        step(4'h1, '0, 1'b0);
        step(4'h8, 64'h80, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h1, '0, 1'b0, '0, 1'b0);

        // Call out of range is caught on the following cycle
        step(4'h8, 64'h7FF, 1'b0);
        step(4'h1, '0, 1'b0);
        step(4'h1, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h1, '0, 1'b0, '0, 1'b0);

        // Exactly at the address limit is legal; one past, ADR beats INS
        step(4'h7, 64'h7F6, 1'b1);
        step(4'h1, '0, 1'b0);
        step(4'hC, '0, 1'b0);
        step(4'h1, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h1, '0, 1'b0, '0, 1'b0);

        // Reset during WAIT_RET with valM present and stall high
        step(4'h1, '0, 1'b0);
        step(4'h9, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'h1, '0, 1'b0, 64'h30, 1'b1);
        step(4'h1, '0, 1'b0);

        // Random legal traffic with random stalls
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 3) == 0), okCodes[$urandom_range(0, 9)],
                          DW'($urandom_range(0, 'h400)), 1'($urandom_range(0, 1)), '0, 1'b0);
        end

        @(negedge clock);
        checkOutput("drain", DW'(expQ.size()), '0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
